// File: rtl/ram_port_sequencer.sv
// Port-B sequencer for the tile/sprite RAM: video/CPU arbitration with
// CPU anti-starvation, plus a hardware clear sweep after reset or on request.
module ram_port_sequencer #(
    parameter int                 ADDR_W       = 11,
    parameter int                 DATA_W       = 8,
    parameter logic [DATA_W-1:0]  CLEAR_VAL    = '0,
    parameter int                 CPU_MAX_WAIT = 3
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              clear_req,
    output logic              clear_busy,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_gnt,
    output logic              vid_valid,
    output logic [DATA_W-1:0] vid_data,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_q
);

    typedef enum logic {ST_CLEAR, ST_SERVE} state_t;

    localparam logic [ADDR_W-1:0] ONE      = 1;
    localparam logic [ADDR_W-1:0] LAST     = '1;
    localparam logic [3:0]        MAX_WAIT = 4'(CPU_MAX_WAIT);

    state_t            r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic [3:0]        r_wait;
    logic              r_busy;
    logic              r_vid_valid;
    logic              r_cpu_ack;
    logic              r_wr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_vid_hold;
    logic [DATA_W-1:0] r_cpu_hold;

    logic              w_clear;
    logic              w_serve;
    logic              w_cpu_gnt;
    logic              w_vid_gnt;
    logic [ADDR_W-1:0] w_clr_addr;
    logic [DATA_W-1:0] w_cpu_rdata;

    // Port outputs are gated by reset so everything reads 0 while held.
    assign w_clear    = reset_n && (r_state == ST_CLEAR);
    assign w_serve    = reset_n && (r_state == ST_SERVE);
    assign w_cpu_gnt  = w_serve && cpu_req && ((r_wait >= MAX_WAIT) || !vid_req);
    assign w_vid_gnt  = w_serve && vid_req && !w_cpu_gnt;
    // A restart writes address 0 in the very cycle it is requested.
    assign w_clr_addr = clear_req ? '0 : r_cnt;

    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        unique case (1'b1)
            w_clear: begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = w_clr_addr;
                ram_wdata = CLEAR_VAL;
            end
            w_cpu_gnt: begin
                ram_en    = 1'b1;
                ram_we    = cpu_we;
                ram_addr  = cpu_addr;
                ram_wdata = cpu_wdata;
            end
            w_vid_gnt: begin
                ram_en    = 1'b1;
                ram_addr  = vid_addr;
            end
            default: ;
        endcase
    end

    assign w_cpu_rdata = r_cpu_ack ? (r_wr ? r_wdata : ram_q) : r_cpu_hold;

    assign clear_busy = r_busy;
    assign vid_gnt    = w_vid_gnt;
    assign cpu_gnt    = w_cpu_gnt;
    assign vid_valid  = r_vid_valid;
    assign cpu_ack    = r_cpu_ack;
    assign vid_data   = r_vid_valid ? ram_q : r_vid_hold;
    assign cpu_rdata  = w_cpu_rdata;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_CLEAR;
            r_cnt       <= '0;
            r_wait      <= '0;
            r_busy      <= 1'b1;
            r_vid_valid <= 1'b0;
            r_cpu_ack   <= 1'b0;
            r_wr        <= 1'b0;
            r_wdata     <= '0;
            r_vid_hold  <= '0;
            r_cpu_hold  <= '0;
        end else begin
            r_vid_valid <= w_vid_gnt;
            r_cpu_ack   <= w_cpu_gnt;
            if (w_cpu_gnt) begin
                r_wr    <= cpu_we;
                r_wdata <= cpu_wdata;
            end
            if (r_vid_valid)
                r_vid_hold <= ram_q;
            if (r_cpu_ack)
                r_cpu_hold <= w_cpu_rdata;
            case (r_state)
                ST_CLEAR: begin
                    r_cnt <= w_clr_addr + ONE;
                    if (w_clr_addr == LAST) begin
                        r_state <= ST_SERVE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    if (clear_req) begin
                        r_state <= ST_CLEAR;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                    end
                    if (w_cpu_gnt)
                        r_wait <= '0;
                    else if (cpu_req && (r_wait != 4'hF))
                        r_wait <= r_wait + 4'd1;
                end
            endcase
        end
    end

endmodule

// File: doc/ram_port_sequencer.md
Name: ram_port_sequencer

Overview:
- Owns one port of a single-cycle synchronous dual-port tile/sprite RAM (1-cycle read latency, write-first readback).
- Shares that port between the video fetch engine (read-only, priority) and the CPU bus (read/write, wait-stated), with an anti-starvation guarantee for the CPU.
- Provides a hardware RAM-clear sequence after reset and on request.
- Sits between the video/CPU address decoders and RAM port B.

Parameters:
- ADDR_W, 11, RAM address width; RAM depth = 2**ADDR_W.
- DATA_W, 8, RAM data width.
- CLEAR_VAL, 0, value written to every location during clear.
- CPU_MAX_WAIT, 3, consecutive denied cycles after which the CPU wins over video (range 1..15).

Ports:
- clock  in  1  single system clock, all logic rising-edge.
- reset_n  in  1  asynchronous active-low reset.
- clear_req  in  1  single-cycle pulse; start or restart a full RAM clear.
- clear_busy  out  1  high while the clear sequence runs.
- vid_req  in  1  video read request; held until vid_gnt.
- vid_addr  in  ADDR_W  video read address.
- vid_gnt  out  1  combinational; video access issued this cycle.
- vid_valid  out  1  registered; vid_data valid this cycle.
- vid_data  out  DATA_W  read data for video.
- cpu_req  in  1  CPU request; held until cpu_gnt.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_gnt  out  1  combinational; CPU access issued this cycle.
- cpu_ack  out  1  registered; access complete, cpu_rdata valid for reads.
- cpu_rdata  out  DATA_W  read data for CPU.
- ram_en, ram_we  out  1 each  RAM port enable and write enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_q  in  DATA_W  RAM read data, valid one cycle after the enabled edge.

Behaviour:
- States: CLEAR, SERVE.
- Reset (asynchronous, reset_n=0):
  - All outputs 0; clear counter = 0; wait counter = 0; state = CLEAR.
  - Exception: clear_busy = 1 during and immediately after reset.
- CLEAR state:
  - Each cycle drives ram_en=1, ram_we=1, ram_addr=counter, ram_wdata=CLEAR_VAL, then increments counter.
  - vid_gnt = cpu_gnt = 0; requests are held off, not dropped.
  - After writing address 2**ADDR_W-1: counter wraps to 0, clear_busy falls at the next edge, state goes to SERVE.
  - A clear takes exactly 2**ADDR_W cycles (2048 at defaults).
- clear_req:
  - In SERVE: enters CLEAR on the next cycle. An access granted in the same cycle still completes its ack/valid.
  - During CLEAR: restarts the counter at 0.
- SERVE arbitration (combinational, per cycle):
  - If cpu_req and wait counter ≥ CPU_MAX_WAIT: CPU wins.
  - Otherwise, if vid_req: video wins.
  - Otherwise, if cpu_req: CPU wins.
  - Otherwise: idle, ram_en = 0.
- Port drive for the winner: ram_en=1, ram_addr from the winner; ram_we = cpu_we and ram_wdata = cpu_wdata only on a CPU grant; ram_we = 0 on a video grant.
- Wait counter:
  - Increments, saturating at 15, each cycle cpu_req=1 and cpu_gnt=0.
  - Clears on cpu_gnt.
  - Holds during CLEAR.
- Latency: grant in cycle N gives a one-cycle ack/valid pulse in cycle N+1.
  - vid_data = ram_q; cpu_rdata = ram_q for reads.
  - Data outputs hold their last value between pulses.
  - For writes cpu_ack pulses and cpu_rdata = written data (write-first).
- Back-to-back: a requester keeping req high after its grant gets a new access. Full throughput is 1 access per cycle.
- Requests must not change address/we/wdata while waiting; violation is undefined.
- Simultaneous vid_req and cpu_req with CPU not starved: video granted, CPU waits.
  - CPU is granted at latest on the (CPU_MAX_WAIT+1)-th cycle of its request.
- No access is ever issued to RAM without exactly one matching ack/valid, except when reset asserts mid-access (pulse suppressed).

Test Plan:
- Release reset → clear_busy=1 for exactly 2048 cycles, ram_we=1 at addresses 0..2047 with data 0x00, then clear_busy=0. Requests held high during clear get no grant until the first SERVE cycle.
- CPU write 0x5A @0x123, then CPU read @0x123 (video idle) → cpu_gnt each request cycle, cpu_ack next cycle, read cpu_rdata=0x5A.
- vid_req held continuously plus cpu_req read → vid_gnt cycles 0–2, cpu_gnt cycle 3 (CPU_MAX_WAIT=3), video resumes cycle 4. Every vid_valid matches the preloaded RAM contents.
- Video-only stream over addresses 0x000..0x00F → 16 consecutive vid_gnt cycles, 16 consecutive vid_valid pulses with correct data, 1 cycle delayed.
- clear_req pulse at clear counter=0x400 → counter restarts at 0, total clear_busy length = 0x400 + 2048 cycles, all locations end CLEAR_VAL.
- Assert reset_n=0 mid CPU read (grant cycle) → all outputs 0 asynchronously, no cpu_ack. After release, the full clear sequence re-runs.
